// File: rtl/dbus_req_buffer.sv
// Registered request buffer between the memory stage and the data bus port.
// It issues one request at a time, holds it until the bus accepts it, and holds the response until the stage advances.
module dbus_req_buffer #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [2:0]          in_size,
  input  logic [DATA_W/8-1:0] in_strobe,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_advance,
  input  logic                kill,
  output logic                in_data_ok,
  output logic [DATA_W-1:0]   in_rdata,
  output logic                bus_valid,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [2:0]          bus_size,
  output logic [DATA_W/8-1:0] bus_strobe,
  output logic [DATA_W-1:0]   bus_data,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                busy,
  output logic                bus_timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t           state;
  logic             killed;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             rsp;
  logic             drop;

  // An addr_ok arriving together with data_ok completes the whole transaction.
  assign rsp     = ((state == ADDR) && bus_addr_ok && bus_data_ok) ||
                   ((state == DATA) && bus_data_ok);
  assign drop    = killed | kill;
  assign cnt_inc = (to_cnt == TO_LIM) ? to_cnt : to_cnt + CNT_W'(1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      killed      <= 1'b0;
      to_cnt      <= '0;
      bus_valid   <= 1'b0;
      bus_addr    <= '0;
      bus_size    <= '0;
      bus_strobe  <= '0;
      bus_data    <= '0;
      in_data_ok  <= 1'b0;
      in_rdata    <= '0;
      bus_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !kill) begin
            bus_addr   <= in_addr;
            bus_size   <= in_size;
            bus_strobe <= in_strobe;
            bus_data   <= in_data;
            bus_valid  <= 1'b1;
            state      <= ADDR;
          end
        end
        ADDR, DATA: begin
          to_cnt <= cnt_inc;
          if ((TIMEOUT_CYC != 0) && (cnt_inc == TO_LIM)) bus_timeout <= 1'b1;
          if (kill) killed <= 1'b1;
          if ((state == ADDR) && bus_addr_ok) begin
            bus_valid <= 1'b0;
            state     <= DATA;
          end
          // A flushed request still finishes on the bus, but its response is dropped.
          if (rsp) begin
            killed <= 1'b0;
            if (drop) begin
              state  <= IDLE;
              to_cnt <= '0;
            end else begin
              state      <= DONE;
              in_rdata   <= bus_rdata;
              in_data_ok <= 1'b1;
            end
          end
        end
        DONE: begin
          if (in_advance || kill) begin
            state      <= IDLE;
            in_data_ok <= 1'b0;
            to_cnt     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_req_buffer.sv
// Randomized bench for dbus_req_buffer: each transaction's expected bus and
// upstream behaviour is derived from its request, bus delays and kill point.
module tb_dbus_req_buffer;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int SW     = DATA_W / 8;
  localparam int TO     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_advance, kill;
  logic [ADDR_W-1:0] in_addr;
  logic [2:0]        in_size;
  logic [SW-1:0]     in_strobe;
  logic [DATA_W-1:0] in_data;
  logic              in_data_ok;
  logic [DATA_W-1:0] in_rdata;
  logic              bus_valid;
  logic [ADDR_W-1:0] bus_addr;
  logic [2:0]        bus_size;
  logic [SW-1:0]     bus_strobe;
  logic [DATA_W-1:0] bus_data;
  logic              bus_addr_ok, bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;
  logic              busy, bus_timeout;

  int n_chk = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_rdata;

  always #5 clk = ~clk;

  dbus_req_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_size(in_size),
    .in_strobe(in_strobe), .in_data(in_data), .in_advance(in_advance),
    .kill(kill), .in_data_ok(in_data_ok), .in_rdata(in_rdata),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_size(bus_size),
    .bus_strobe(bus_strobe), .bus_data(bus_data),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .busy(busy), .bus_timeout(bus_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bus_valid"}, 64'(bus_valid), 64'd0);
    chk({tag, "_bus_addr"}, bus_addr, 64'd0);
    chk({tag, "_bus_size"}, 64'(bus_size), 64'd0);
    chk({tag, "_bus_strobe"}, 64'(bus_strobe), 64'd0);
    chk({tag, "_bus_data"}, bus_data, 64'd0);
    chk({tag, "_data_ok"}, 64'(in_data_ok), 64'd0);
    chk({tag, "_rdata"}, in_rdata, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_timeout"}, 64'(bus_timeout), 64'd0);
  endtask

  // One request; aw = cycles before addr_ok, dw = cycles from addr_ok to data_ok,
  // kill_at = bus-phase cycle carrying a kill pulse (-1: none).
  task automatic run_req(input logic [63:0] a, input logic [2:0] sz, input logic [SW-1:0] st,
                         input logic [63:0] d, input int aw, input int dw, input logic [63:0] rd,
                         input int kill_at, input int hold, input bit end_by_kill);
    int nvalid;
    bit killed;
    nvalid = 0;
    killed = 0;
    in_valid = 1'b1; in_addr = a; in_size = sz; in_strobe = st; in_data = d;
    kill = 1'b0; in_advance = 1'b0;
    step();
    // Upstream fields change after capture; the bus copy must not follow.
    in_addr = {$urandom, $urandom}; in_data = {$urandom, $urandom};
    in_strobe = SW'($urandom); in_size = 3'($urandom);
    for (int c = 0; c <= aw + dw; c++) begin
      chk("bus_valid", 64'(bus_valid), 64'(c <= aw));
      if (bus_valid) nvalid++;
      chk("bus_addr", bus_addr, a);
      chk("bus_size", 64'(bus_size), 64'(sz));
      chk("bus_strobe", 64'(bus_strobe), 64'(st));
      chk("bus_data", bus_data, d);
      chk("busy_txn", 64'(busy), 64'd1);
      chk("data_ok_early", 64'(in_data_ok), 64'd0);
      chk("timeout_clear", 64'(bus_timeout), 64'd0);
      bus_addr_ok = (c == aw);
      bus_data_ok = (c == aw + dw);
      bus_rdata   = (c == aw + dw) ? rd : {$urandom, $urandom};
      kill        = (c == kill_at);
      if (c == kill_at) begin
        killed   = 1;
        in_valid = 1'b0;
      end
      step();
    end
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; kill = 1'b0;
    chk("valid_cycles", 64'(nvalid), 64'(aw + 1));
    chk("bus_valid_after", 64'(bus_valid), 64'd0);
    if (killed) begin
      chk("killed_data_ok", 64'(in_data_ok), 64'd0);
      chk("killed_busy", 64'(busy), 64'd0);
      chk("killed_rdata", in_rdata, exp_rdata);
    end else begin
      exp_rdata = rd;
      chk("data_ok", 64'(in_data_ok), 64'd1);
      chk("rdata", in_rdata, exp_rdata);
      for (int h = 0; h < hold; h++) begin
        bus_data_ok = 1'($urandom_range(0, 1));
        bus_rdata   = {$urandom, $urandom};
        step();
        chk("hold_data_ok", 64'(in_data_ok), 64'd1);
        chk("hold_rdata", in_rdata, exp_rdata);
        chk("hold_bus_valid", 64'(bus_valid), 64'd0);
        chk("hold_busy", 64'(busy), 64'd1);
      end
      bus_data_ok = 1'b0;
      in_valid = 1'b0;
      if (end_by_kill) kill = 1'b1;
      else in_advance = 1'b1;
      step();
      kill = 1'b0; in_advance = 1'b0;
      chk("release_data_ok", 64'(in_data_ok), 64'd0);
      chk("release_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_size = '0; in_strobe = '0;
    in_data = '0; in_advance = 1'b0; kill = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    exp_rdata = '0;
    repeat (3) step();
    reset = 1'b0;
    chk_zero("reset");

    run_req(64'h8000_0010, 3'd3, '0, '0, 2, 3, 64'hDEAD_BEEF_0123_4567, -1, 2, 0);
    run_req(64'h8000_0020, 3'd2, SW'(8'h0F), 64'h1122_3344, 0, 0, 64'h55, -1, 0, 0);
    run_req(64'h8000_0030, 3'd3, '0, '0, 3, 2, 64'hCAFE, 1, 0, 0);
    run_req(64'h8000_0040, 3'd3, '0, '0, 1, 1, 64'h0BAD_F00D, -1, 5, 0);

    for (int i = 0; i < 40; i++) begin
      int aw, dw, ka;
      aw = $urandom_range(0, 2);
      dw = $urandom_range(0, 3);
      ka = ($urandom_range(0, 3) == 0 && aw + dw > 0) ? $urandom_range(0, aw + dw - 1) : -1;
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        in_valid = 1'($urandom_range(0, 1));
        kill = in_valid;
        step();
        chk("gap_busy", 64'(busy), 64'd0);
        chk("gap_bus_valid", 64'(bus_valid), 64'd0);
      end
      in_valid = 1'b0; kill = 1'b0;
      run_req({$urandom, $urandom}, 3'($urandom), ($urandom_range(0, 1) != 0) ? SW'($urandom) : '0,
              {$urandom, $urandom}, aw, dw, {$urandom, $urandom}, ka,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Bus never accepts: the flag appears after TO ADDR cycles and sticks.
    in_valid = 1'b1; in_addr = 64'h9000_0000; in_strobe = '0;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == TO - 1) chk("timeout_early", 64'(bus_timeout), 64'd0);
      if (k >= TO) begin
        chk("timeout_set", 64'(bus_timeout), 64'd1);
        chk("timeout_valid", 64'(bus_valid), 64'd1);
      end
    end
    bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0;
    chk("to_data_valid", 64'(bus_valid), 64'd0);
    chk("to_data_busy", 64'(busy), 64'd1);
    chk("timeout_sticky", 64'(bus_timeout), 64'd1);
    step();

    // Reset while waiting on data, then a stale response.
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_rdata = '0;
    chk_zero("midreset");
    step();
    bus_data_ok = 1'b1; bus_rdata = 64'hFFFF_0000_FFFF_0000;
    step();
    bus_data_ok = 1'b0;
    chk_zero("stale");
    step();
    chk_zero("stale2");

    run_req(64'h8000_0100, 3'd3, '0, '0, 1, 2, 64'h1234_5678_9ABC_DEF0, -1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
